// File: rtl/ps2_rx_frame_pkg.sv
// Shared PS/2 receive definitions: frame layout, FSM states and well-known scan-code prefixes.
package ps2_rx_frame_pkg;

   localparam int unsigned PS2_FRAME_LEN = 11;
   localparam int unsigned PS2_DATA_BITS = 8;
   localparam logic [7:0]  PS2_BREAK     = 8'hF0;
   localparam logic [7:0]  PS2_EXT       = 8'hE0;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

endpackage

// File: rtl/ps2_rx_frame_fifo.sv
// Byte FIFO with extra-wrap-bit pointers; a push while full is dropped unless a pop frees a slot.
module ps2_rx_frame_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [7:0]                 i_din,
   output logic                       o_full,
   input  logic                       i_pop,
   output logic [7:0]                 o_dout,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_wr_en;
   logic        w_rd_en;

   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count    = r_wr_ptr - r_rd_ptr;
   assign o_dout     = r_mem[r_rd_ptr[AW-1:0]];
   assign w_rd_en    = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_wr_en    = i_push & (~o_full | w_rd_en);
   assign o_overflow = i_push & o_full & ~w_rd_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronises the pins, deserialises 11-bit odd-parity frames and
// buffers good bytes for the display stage.
module ps2_rx_frame
   import ps2_rx_frame_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ps2_clk,
   input  logic                          ps2_dat,
   input  logic                          out_ready,
   output logic [7:0]                    ps2_data,
   output logic                          ps2_valid,
   output logic                          ps2_recFlag,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   w_clk_s;
   logic                   w_dat_s;
   logic                   w_fall;

   ps2_state_e r_state, w_state_d;
   logic [7:0]    r_shreg, w_shreg_d;
   logic [2:0]    r_bit_cnt, w_bit_cnt_d;
   logic          r_par_ok, w_par_ok_d;
   logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_d;
   logic          r_parity_err, w_parity_err_d;
   logic          r_frame_err, w_frame_err_d;
   logic          r_overflow;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic          w_fifo_ovf;

   assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
   assign w_fall  = r_clk_prev & ~w_clk_s;

   // Sync flops reset to the idle-high line level so reset release cannot fake a falling edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
         r_clk_prev <= w_clk_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_shreg      <= '0;
         r_bit_cnt    <= '0;
         r_par_ok     <= 1'b0;
         r_tmo_cnt    <= '0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_shreg      <= w_shreg_d;
         r_bit_cnt    <= w_bit_cnt_d;
         r_par_ok     <= w_par_ok_d;
         r_tmo_cnt    <= w_tmo_cnt_d;
         r_parity_err <= w_parity_err_d;
         r_frame_err  <= w_frame_err_d;
         r_overflow   <= w_fifo_ovf;
      end
   end

   always_comb begin
      w_state_d      = r_state;
      w_shreg_d      = r_shreg;
      w_bit_cnt_d    = r_bit_cnt;
      w_par_ok_d     = r_par_ok;
      w_tmo_cnt_d    = '0;
      w_parity_err_d = 1'b0;
      w_frame_err_d  = 1'b0;
      w_push         = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (w_fall && !w_dat_s) begin
               w_state_d   = StData;
               w_bit_cnt_d = '0;
            end
         end
         StData: begin
            if (w_fall) begin
               w_shreg_d   = {w_dat_s, r_shreg[7:1]};
               w_bit_cnt_d = r_bit_cnt + 1'b1;
               if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) w_state_d = StParity;
            end
         end
         StParity: begin
            if (w_fall) begin
               w_par_ok_d = ^{r_shreg, w_dat_s};
               w_state_d  = StStop;
            end
         end
         StStop: begin
            if (w_fall) begin
               // A parity failure takes precedence over a bad stop bit.
               if (!r_par_ok)    w_parity_err_d = 1'b1;
               else if (w_dat_s) w_push         = 1'b1;
               else              w_frame_err_d  = 1'b1;
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (r_state != StIdle && !w_fall) begin
         if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_d     = StIdle;
            w_frame_err_d = 1'b1;
         end else begin
            w_tmo_cnt_d = r_tmo_cnt + 1'b1;
         end
      end
   end

   ps2_rx_frame_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_din      (r_shreg),
      .o_full     (w_full),
      .i_pop      (ps2_recFlag),
      .o_dout     (ps2_data),
      .o_empty    (w_empty),
      .o_count    (fifo_count),
      .o_overflow (w_fifo_ovf)
   );

   assign ps2_valid   = ~w_empty;
   assign ps2_recFlag = ps2_valid & out_ready;
   assign parity_err  = r_parity_err;
   assign frame_err   = r_frame_err;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomised bench for ps2_rx_frame: frames driven on the pins, results checked against a byte-queue
// model with expected error-pulse tallies.
module tb_ps2_rx_frame;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TMO   = 400;
   localparam int unsigned HALF  = 10;
   localparam int unsigned GAP   = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       out_ready = 1'b0;
   logic [7:0] ps2_data;
   logic       ps2_valid;
   logic       ps2_recFlag;
   logic [3:0] fifo_count;
   logic       parity_err;
   logic       frame_err;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] q[$];
   int exp_par = 0, exp_frm = 0, exp_ovf = 0;
   int got_par = 0, got_frm = 0, got_ovf = 0;

   ps2_rx_frame #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (TMO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_dat     (ps2_dat),
      .out_ready   (out_ready),
      .ps2_data    (ps2_data),
      .ps2_valid   (ps2_valid),
      .ps2_recFlag (ps2_recFlag),
      .fifo_count  (fifo_count),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Consumer side: every pop must match the oldest byte the model expects.
   always @(negedge clk) begin
      if (rst) begin
         if (parity_err) got_par++;
         if (frame_err)  got_frm++;
         if (overflow)   got_ovf++;
         if (ps2_recFlag) begin
            if (q.size() == 0) check("rx_unexpected", 32'(ps2_data) | 32'h100, 32'h0);
            else               check("rx_data", 32'(ps2_data), 32'(q.pop_front()));
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop);
      logic par;
      par = ~(^d) ^ flip_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(par);
      ps2_dat = ~bad_stop;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      if (flip_par)              exp_par++;
      else if (bad_stop)         exp_frm++;
      else if (q.size() < DEPTH) q.push_back(d);
      else                       exp_ovf++;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      wait_cycles(GAP);
   endtask

   task automatic checkpoint(input string tag);
      check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
      check({tag, "_valid"}, 32'(ps2_valid), 32'(q.size() != 0));
      check({tag, "_par"},   32'(got_par), 32'(exp_par));
      check({tag, "_frm"},   32'(got_frm), 32'(exp_frm));
      check({tag, "_ovf"},   32'(got_ovf), 32'(exp_ovf));
   endtask

   initial begin
      logic [7:0] d;
      int kind;

      wait_cycles(5);
      check("rst_valid",   32'(ps2_valid), 0);
      check("rst_count",   32'(fifo_count), 0);
      check("rst_data",    32'(ps2_data), 0);
      check("rst_recflag", 32'(ps2_recFlag), 0);
      check("rst_pulses",  32'({parity_err, frame_err, overflow}), 0);
      rst = 1'b1;
      wait_cycles(5);

      out_ready = 1'b1;
      send_frame(8'h1C, 1'b0, 1'b0);
      checkpoint("single");

      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      checkpoint("b2b");

      send_frame(8'h16, 1'b1, 1'b0);
      checkpoint("par_bad");
      send_frame(8'h1E, 1'b0, 1'b0);
      checkpoint("par_next");

      // Partial 0x45 frame, then the clock line stalls high.
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'(8'h45 >> i));
      ps2_dat = 1'b1;
      wait_cycles(TMO + 20);
      exp_frm++;
      checkpoint("timeout");
      send_frame(8'h45, 1'b0, 1'b0);
      checkpoint("tmo_next");

      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_frame(8'($urandom), 1'b0, 1'b0);
      checkpoint("full");
      out_ready = 1'b1;
      wait_cycles(20);
      checkpoint("drain");

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 1'b0);
      checkpoint("pre_rst");
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
      rst = 1'b0;
      q.delete();
      wait_cycles(3);
      check("midrst_count", 32'(fifo_count), 0);
      check("midrst_valid", 32'(ps2_valid), 0);
      ps2_dat = 1'b1;
      rst = 1'b1;
      wait_cycles(10);
      out_ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0);
      checkpoint("post_rst");

      for (int n = 0; n < 24; n++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         d = 8'($urandom);
         kind = $urandom_range(0, 9);
         send_frame(d, (kind == 0 || kind == 2), (kind == 1 || kind == 2));
      end
      out_ready = 1'b1;
      wait_cycles(20);
      checkpoint("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
